// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode stage and the ALU datapath:
// instruction field layout, opcode encoding and the fetch/decode state set.
package isa_pkg;

   localparam int unsigned INS_W  = 19;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned DATA_W = 8;

   localparam int unsigned OP_HI = 18;
   localparam int unsigned OP_LO = 16;
   localparam int unsigned A_HI  = 15;
   localparam int unsigned A_LO  = 8;
   localparam int unsigned B_HI  = 7;
   localparam int unsigned B_LO  = 0;

   typedef enum logic [OP_W-1:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SHL,
      OP_SHR,
      OP_PASS
   } op_t;

   typedef enum logic [1:0] {
      FETCH,
      ISSUE,
      WAIT,
      HALT
   } fd_state_t;

endpackage

// File: rtl/fetch_decode_if.sv
// ROM read port plus decoded-field valid/ready channel between fetch_decode
// (master) and its ROM / downstream ALU (slave).
interface fetch_decode_if #(
   parameter int unsigned ADDR_W = 5
) ();
   import isa_pkg::*;

   logic [ADDR_W-1:0] rom_addr;
   logic [INS_W-1:0]  rom_data;
   logic [OP_W-1:0]   out_op;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic [INS_W-1:0]  out_ins;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output rom_addr, out_op, out_a, out_b, out_ins, out_valid,
      input  rom_data, out_ready
   );

   modport slave (
      input  rom_addr, out_op, out_a, out_b, out_ins, out_valid,
      output rom_data, out_ready
   );

endinterface

// File: rtl/fetch_decode_pc.sv
// Program counter for fetch_decode: synchronous clear, increment, and explicit
// wrap to zero after LAST_ADDR.
module pc_counter #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned LAST_ADDR = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(LAST_ADDR);

   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (inc) begin
         pc_d = (pc_q == LastPc) ? '0 : pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: walks the PC over the ROM and issues decoded fields over
// valid/ready. Define FETCH_CNT_EN to add the 16-bit issued_cnt port.
module fetch_decode
   import isa_pkg::*;
#(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned LAST_ADDR = 31,
   parameter bit          WRAP      = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           m,
   input  logic           step,
   fetch_decode_if.master bus,
   output logic           halted
`ifdef FETCH_CNT_EN
   ,
   output logic [15:0]    issued_cnt
`endif
);

   localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(LAST_ADDR);

   fd_state_t         state_q, state_d;
   logic [INS_W-1:0]  ins_q, ins_d;
   logic [ADDR_W-1:0] pc;
   logic              pc_inc;
   logic              handshake;

   pc_counter #(
      .ADDR_W    (ADDR_W),
      .LAST_ADDR (LAST_ADDR)
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_inc),
      .pc    (pc)
   );

   assign handshake = (state_q == ISSUE) && bus.out_ready;

   always_comb begin
      state_d = state_q;
      ins_d   = ins_q;
      pc_inc  = 1'b0;
      unique case (state_q)
         FETCH: begin
            ins_d   = bus.rom_data;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (bus.out_ready) begin
               if ((pc == LastPc) && !WRAP) begin
                  state_d = HALT;
               end else begin
                  pc_inc  = 1'b1;
                  state_d = m ? FETCH : WAIT;
               end
            end
         end
         WAIT: begin
            // Switching to run mode releases the wait without a step pulse.
            if (m || step) begin
               state_d = FETCH;
            end
         end
         HALT: state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         ins_q   <= '0;
      end else begin
         state_q <= state_d;
         ins_q   <= ins_d;
      end
   end

   assign bus.rom_addr  = pc;
   assign bus.out_ins   = ins_q;
   assign bus.out_op    = ins_q[OP_HI:OP_LO];
   assign bus.out_a     = ins_q[A_HI:A_LO];
   assign bus.out_b     = ins_q[B_HI:B_LO];
   assign bus.out_valid = (state_q == ISSUE);
   assign halted        = (state_q == HALT);

`ifdef FETCH_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   assign cnt_d = handshake ? cnt_q + 16'd1 : cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign issued_cnt = cnt_q;
`else
   logic unused_handshake;
   assign unused_handshake = handshake;
`endif

endmodule
